dro_bank: RTL and testbench

//   N-channel clocked destructive-readout (DRO) cell bank. It is the synchronous, parametrised successor
//   of the single behavioural DRO model. Each channel stores one bit written by a set event and

---
 rtl/dro_bank.sv | 170 +++++++++++++++++
 tb/tb_dro_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dro_bank.sv
// dro_bank: N-channel clocked destructive-readout (DRO) cell bank.
//   Each channel stores one bit written by a set event and emits it on a
//   clear (read) event. An event is any level transition on set/clr. The
//   block adds a programmable output delay, a toggle or pulse output mode,
//   an init blackout window after reset, and hold-time violation detection
//   with a saturating counter.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   set[N]     - per-channel write line (each edge is one event)
//   clr[N]     - per-channel destructive-read line (each edge is one event)
//   viol_clear - clears viol and viol_count
//   out[N]     - read-out (MODE 0: level toggle, MODE 1: 1-cycle pulse), DELAY cycles late
//   state[N]   - stored bit per channel
//   armed      - high once the INIT window has elapsed
//   viol[N]    - sticky per-channel hold violation flag
//   viol_count - saturating count of violation events over all channels
module dro_bank #(
  parameter int unsigned N     = 4,
  parameter int unsigned DELAY = 2,
  parameter int unsigned HOLD  = 3,
  parameter int unsigned INIT  = 8,
  parameter int unsigned MODE  = 0,
  parameter int unsigned CW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  set,
  input  logic [N-1:0]  clr,
  input  logic          viol_clear,
  output logic [N-1:0]  out,
  output logic [N-1:0]  state,
  output logic          armed,
  output logic [N-1:0]  viol,
  output logic [CW-1:0] viol_count
);

  localparam int unsigned IW        = (INIT > 0) ? $clog2(INIT + 1) : 1;
  localparam int unsigned INIT_LAST = (INIT > 0) ? INIT - 1 : 0;
  localparam int unsigned TW        = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam int unsigned PW        = $clog2(N + 1);
  localparam int unsigned SW        = CW + PW;

  logic [N-1:0]  set_q, set_d;
  logic [N-1:0]  clr_q, clr_d;
  logic [N-1:0]  state_q, state_d;
  logic [N-1:0]  core_q, core_d;
  logic [N-1:0]  viol_q, viol_d;
  logic [CW-1:0] viol_count_q, viol_count_d;
  logic          armed_q, armed_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [TW-1:0] timer_q [N];
  logic [TW-1:0] timer_d [N];
  logic [N-1:0]  last_set_q, last_set_d;

  logic [N-1:0]  set_ev, clr_ev, fire, near, vnow;
  logic [PW-1:0] pop;
  logic [SW-1:0] sum;
  logic [CW-1:0] count_base;

  always_comb begin
    set_d        = set;
    clr_d        = clr;
    set_ev       = set ^ set_q;
    clr_ev       = clr ^ clr_q;
    armed_d      = armed_q;
    init_cnt_d   = init_cnt_q;
    state_d      = state_q;
    core_d       = (MODE == 0) ? core_q : '0;
    timer_d      = timer_q;
    last_set_d   = last_set_q;
    near         = '0;
    vnow         = '0;
    pop          = '0;

    if (!armed_q) begin
      init_cnt_d = init_cnt_q + IW'(1);
      if (INIT == 0 || init_cnt_q == IW'(INIT_LAST)) armed_d = 1'b1;
    end

    // Read-out is judged on the old state; set wins over clr for the new state.
    fire = clr_ev & state_q & {N{armed_q}};

    if (armed_q) begin
      state_d = (state_q & ~clr_ev) | set_ev;
      core_d  = (MODE == 0) ? (core_q ^ fire) : fire;
      if (HOLD > 0) begin
        for (int unsigned i = 0; i < N; i++) begin
          near[i] = (timer_q[i] < TW'(HOLD));
          vnow[i] = (set_ev[i] & clr_ev[i])
                  | (set_ev[i] & ~last_set_q[i] & near[i])
                  | (clr_ev[i] &  last_set_q[i] & near[i]);
          if (set_ev[i] | clr_ev[i]) begin
            // Timer holds the distance to the last event as seen at the next edge.
            timer_d[i]    = TW'(1);
            last_set_d[i] = set_ev[i];
          end else if (near[i]) begin
            timer_d[i] = timer_q[i] + TW'(1);
          end
        end
      end
    end

    for (int unsigned i = 0; i < N; i++) begin
      pop = pop + PW'(vnow[i]);
    end

    // Clear applies first so a same-cycle violation survives it.
    viol_d     = (viol_clear ? '0 : viol_q) | vnow;
    count_base = viol_clear ? '0 : viol_count_q;
    sum        = SW'(count_base) + SW'(pop);
    if (sum > SW'({CW{1'b1}})) viol_count_d = '1;
    else                       viol_count_d = sum[CW-1:0];
  end

  always_ff @(posedge clk) begin
    set_q <= set_d;
    clr_q <= clr_d;
    if (rst) begin
      state_q      <= '0;
      core_q       <= '0;
      viol_q       <= '0;
      viol_count_q <= '0;
      armed_q      <= 1'b0;
      init_cnt_q   <= '0;
      last_set_q   <= '0;
      for (int unsigned i = 0; i < N; i++) timer_q[i] <= TW'(HOLD);
    end else begin
      state_q      <= state_d;
      core_q       <= core_d;
      viol_q       <= viol_d;
      viol_count_q <= viol_count_d;
      armed_q      <= armed_d;
      init_cnt_q   <= init_cnt_d;
      last_set_q   <= last_set_d;
      for (int unsigned i = 0; i < N; i++) timer_q[i] <= timer_d[i];
    end
  end

  generate
    if (DELAY == 0) begin : g_nodly
      assign out = core_q;
    end else begin : g_dly
      logic [N-1:0] pipe_q [DELAY];
      logic [N-1:0] pipe_d [DELAY];

      always_comb begin
        pipe_d[0] = core_q;
        for (int unsigned i = 1; i < DELAY; i++) pipe_d[i] = pipe_q[i-1];
      end

      // Reset flushes in-flight read-outs so nothing emerges after release.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int unsigned i = 0; i < DELAY; i++) pipe_q[i] <= '0;
        end else begin
          for (int unsigned i = 0; i < DELAY; i++) pipe_q[i] <= pipe_d[i];
        end
      end

      assign out = pipe_q[DELAY-1];
    end
  endgenerate

  assign state      = state_q;
  assign armed      = armed_q;
  assign viol       = viol_q;
  assign viol_count = viol_count_q;

endmodule

// File: tb/tb_dro_bank.sv
// tb_dro_bank: table-driven bench for dro_bank with a reference model and
//   an output scoreboard. Two instances share stimulus: u0 (MODE 0, CW 8)
//   and u1 (MODE 1, CW 2). Each row of the table is one clock edge.
module tb_dro_bank;
  localparam int N     = 4;
  localparam int DELAY = 2;
  localparam int HOLD  = 3;
  localparam int INIT  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [N-1:0] set, clr;
  logic         viol_clear;
  logic [N-1:0] out0, state0, viol0, out1, state1, viol1;
  logic         armed0, armed1;
  logic [7:0]   cnt0;
  logic [1:0]   cnt1;

  dro_bank #(.N(N), .DELAY(DELAY), .HOLD(HOLD), .INIT(INIT), .MODE(0), .CW(8)) u0 (
    .clk(clk), .rst(rst), .set(set), .clr(clr), .viol_clear(viol_clear),
    .out(out0), .state(state0), .armed(armed0), .viol(viol0), .viol_count(cnt0));

  dro_bank #(.N(N), .DELAY(DELAY), .HOLD(HOLD), .INIT(INIT), .MODE(1), .CW(2)) u1 (
    .clk(clk), .rst(rst), .set(set), .clr(clr), .viol_clear(viol_clear),
    .out(out1), .state(state1), .armed(armed1), .viol(viol1), .viol_count(cnt1));

  typedef struct {
    logic         rst;
    logic [N-1:0] ts;
    logic [N-1:0] tc;
    logic         vc;
    bit           chk;
    logic [N-1:0] e_state;
    logic         e_armed;
    logic [N-1:0] e_viol;
    logic [1:0]   e_cnt1;
  } row_t;

  row_t rows[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // reference model
  logic [N-1:0] m_set_q, m_clr_q, m_state, m_viol, m_core;
  logic         m_armed;
  int           m_rel, m_cnt0, m_cnt1;
  int           last_cyc[N];
  bit           last_set[N];
  logic [N-1:0] sb0[$], sb1[$];
  logic [N-1:0] exp_out0, exp_out1;

  task automatic add(input logic r, input logic [N-1:0] ts, input logic [N-1:0] tc, input logic vc);
    row_t x;
    x.rst = r; x.ts = ts; x.tc = tc; x.vc = vc; x.chk = 1'b0;
    x.e_state = '0; x.e_armed = 1'b0; x.e_viol = '0; x.e_cnt1 = '0;
    rows.push_back(x);
  endtask

  task automatic addc(input logic r, input logic [N-1:0] ts, input logic [N-1:0] tc, input logic vc,
                      input logic [N-1:0] es, input logic ea, input logic [N-1:0] ev, input logic [1:0] ec);
    row_t x;
    x.rst = r; x.ts = ts; x.tc = tc; x.vc = vc; x.chk = 1'b1;
    x.e_state = es; x.e_armed = ea; x.e_viol = ev; x.e_cnt1 = ec;
    rows.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) add(1'b0, '0, '0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [N-1:0] s, input logic [N-1:0] c, input logic vc);
    logic [N-1:0] sev, cev, pulse;
    bit           active, v;
    int           nv;
    cyc++;
    if (r) begin
      m_set_q = s; m_clr_q = c;
      m_state = '0; m_viol = '0; m_core = '0;
      m_cnt0 = 0; m_cnt1 = 0; m_rel = 0; m_armed = 1'b0;
      for (int i = 0; i < N; i++) begin last_cyc[i] = -1000; last_set[i] = 1'b0; end
      sb0.delete(); sb1.delete();
      for (int k = 0; k < DELAY; k++) begin sb0.push_back('0); sb1.push_back('0); end
      sb0.push_back('0); sb1.push_back('0);
    end else begin
      sev = s ^ m_set_q; cev = c ^ m_clr_q;
      m_set_q = s; m_clr_q = c;
      active = (m_rel >= INIT) && (m_rel >= 1);
      if (m_rel < 1000) m_rel++;
      m_armed = (m_rel >= INIT);
      if (vc) begin m_viol = '0; m_cnt0 = 0; m_cnt1 = 0; end
      pulse = '0; nv = 0;
      if (active) begin
        for (int i = 0; i < N; i++) begin
          if (cev[i] && m_state[i]) pulse[i] = 1'b1;
          v = 1'b0;
          if (HOLD > 0) begin
            if (sev[i] && cev[i]) v = 1'b1;
            else if (sev[i] && !last_set[i] && (cyc - last_cyc[i]) < HOLD) v = 1'b1;
            else if (cev[i] &&  last_set[i] && (cyc - last_cyc[i]) < HOLD) v = 1'b1;
          end
          if (sev[i] || cev[i]) begin last_cyc[i] = cyc; last_set[i] = sev[i]; end
          if (sev[i]) m_state[i] = 1'b1;
          else if (cev[i]) m_state[i] = 1'b0;
          if (v) begin m_viol[i] = 1'b1; nv++; end
        end
      end
      m_cnt0 = (m_cnt0 + nv > 255) ? 255 : m_cnt0 + nv;
      m_cnt1 = (m_cnt1 + nv > 3)   ? 3   : m_cnt1 + nv;
      m_core = m_core ^ pulse;
      sb0.push_back(m_core);
      sb1.push_back(pulse);
    end
    exp_out0 = sb0.pop_front();
    exp_out1 = sb1.pop_front();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d got=running want=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; set = '0; clr = '0; viol_clear = 1'b0;

    // reset, init blackout with an ignored set event on ch1
    add (1'b1, '0, '0, 1'b0);
    addc(1'b1, '0, '0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0);
    idle(2);
    addc(1'b0, 4'b0010, '0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0);   // e3
    idle(3);
    addc(1'b0, '0, '0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0);        // e7
    addc(1'b0, '0, '0, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0);        // e8 armed
    // basic write then read on ch0
    addc(1'b0, 4'b0001, '0, 1'b0, 4'b0001, 1'b1, 4'b0000, 2'd0);   // e9
    idle(4);
    addc(1'b0, '0, 4'b0001, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0);   // e14
    idle(5);
    // hold violation on ch2 at distance 2, then clean at distance 3
    add (1'b0, 4'b0100, '0, 1'b0);                                 // e20
    idle(1);
    addc(1'b0, '0, 4'b0100, 1'b0, 4'b0000, 1'b1, 4'b0100, 2'd1);   // e22
    idle(3);
    add (1'b0, 4'b0100, '0, 1'b0);                                 // e26
    idle(2);
    addc(1'b0, '0, 4'b0100, 1'b0, 4'b0000, 1'b1, 4'b0100, 2'd1);   // e29
    idle(2);
    // simultaneous set & clr on a holding ch3
    add (1'b0, 4'b1000, '0, 1'b0);                                 // e32
    idle(7);
    addc(1'b0, 4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 4'b1100, 2'd2); // e40
    idle(4);
    // drive the 2-bit counter into saturation
    add (1'b0, 4'b0001, 4'b0001, 1'b0);                            // e45
    add (1'b0, 4'b0010, 4'b0010, 1'b0);                            // e46
    addc(1'b0, 4'b0100, 4'b0100, 1'b0, 4'b1111, 1'b1, 4'b1111, 2'd3); // e47
    idle(2);
    // clear together with a 2-channel violation
    addc(1'b0, 4'b0011, 4'b0011, 1'b1, 4'b1111, 1'b1, 4'b0011, 2'd2); // e50
    idle(2);
    addc(1'b0, '0, '0, 1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0);        // e53
    idle(2);
    // read-out then reset one cycle later: nothing may emerge
    add (1'b0, '0, 4'b0001, 1'b0);                                 // e56
    addc(1'b1, '0, '0, 1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0);        // e57
    idle(14);
    addc(1'b0, '0, '0, 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0);

    foreach (rows[k]) begin
      @(negedge clk);
      rst        = rows[k].rst;
      set        = set ^ rows[k].ts;
      clr        = clr ^ rows[k].tc;
      viol_clear = rows[k].vc;
      model_step(rst, set, clr, viol_clear);
      @(posedge clk);
      #1;
      chk("state0", 32'(state0), 32'(m_state));
      chk("state1", 32'(state1), 32'(m_state));
      chk("armed0", 32'(armed0), 32'(m_armed));
      chk("armed1", 32'(armed1), 32'(m_armed));
      chk("viol0",  32'(viol0),  32'(m_viol));
      chk("viol1",  32'(viol1),  32'(m_viol));
      chk("cnt0",   32'(cnt0),   32'(m_cnt0));
      chk("cnt1",   32'(cnt1),   32'(m_cnt1));
      chk("out0",   32'(out0),   32'(exp_out0));
      chk("out1",   32'(out1),   32'(exp_out1));
      if (rows[k].chk) begin
        chk("tbl_state", 32'(state0), 32'(rows[k].e_state));
        chk("tbl_armed", 32'(armed1), 32'(rows[k].e_armed));
        chk("tbl_viol",  32'(viol1),  32'(rows[k].e_viol));
        chk("tbl_cnt1",  32'(cnt1),   32'(rows[k].e_cnt1));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
